// File: rtl/imu_sample_framer.sv
// Assembles six-byte IMU frames (GH GL YH YL ZH ZL) into gyro/accel words with gap timeout.
// Define IMU_FRAMER_CAL_EN to subtract GYRO_OFFSET from the gyro word with saturation.
module imu_sample_framer #(
    parameter int unsigned        TIMEOUT_CYCLES = 1000,
    parameter logic signed [15:0] GYRO_OFFSET    = 16'sd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        sof,
    output logic [15:0] gyroData,
    output logic [15:0] y_accel_data,
    output logic [15:0] z_accel_data,
    output logic        sample_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned GAP_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        G_L  = 3'd1,
        Y_H  = 3'd2,
        Y_L  = 3'd3,
        Z_H  = 3'd4,
        Z_L  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       gh_q, gh_d, gl_q, gl_d, yh_q, yh_d, yl_q, yl_d, zh_q, zh_d;
    logic [15:0]      gyro_q, gyro_d, y_q, y_d, z_q, z_d;
    logic             sample_valid_q, sample_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic [15:0]      gyro_word_c;

    // Calibrated gyro word: 17-bit signed difference clamped into 16 bits.
`ifdef IMU_FRAMER_CAL_EN
    logic [16:0] gyro_diff_c;
    always_comb begin
        gyro_diff_c = {gh_q[7], gh_q, gl_q} - {GYRO_OFFSET[15], GYRO_OFFSET};
        if (gyro_diff_c[16] != gyro_diff_c[15]) begin
            gyro_word_c = gyro_diff_c[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            gyro_word_c = gyro_diff_c[15:0];
        end
    end
`else
    logic unused_offset_c;
    assign unused_offset_c = ^GYRO_OFFSET;
    assign gyro_word_c     = {gh_q, gl_q};
`endif

    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        gh_d           = gh_q;
        gl_d           = gl_q;
        yh_d           = yh_q;
        yl_d           = yl_q;
        zh_d           = zh_q;
        gyro_d         = gyro_q;
        y_d            = y_q;
        z_d            = z_q;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;

        if (byte_valid && sof) begin
            // A start byte always opens a fresh frame, aborting any partial one.
            frame_err_d = (state_q != IDLE);
            gh_d        = byte_in;
            gl_d        = 8'h00;
            yh_d        = 8'h00;
            yl_d        = 8'h00;
            zh_d        = 8'h00;
            gap_d       = '0;
            state_d     = G_L;
        end else if (byte_valid && (state_q != IDLE)) begin
            gap_d = '0;
            case (state_q)
                G_L: begin gl_d = byte_in; state_d = Y_H; end
                Y_H: begin yh_d = byte_in; state_d = Y_L; end
                Y_L: begin yl_d = byte_in; state_d = Z_H; end
                Z_H: begin zh_d = byte_in; state_d = Z_L; end
                Z_L: begin
                    gyro_d         = gyro_word_c;
                    y_d            = {yh_q, yl_q};
                    z_d            = {zh_q, byte_in};
                    sample_valid_d = 1'b1;
                    gh_d           = 8'h00;
                    gl_d           = 8'h00;
                    yh_d           = 8'h00;
                    yl_d           = 8'h00;
                    zh_d           = 8'h00;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (gap_q == GAP_LAST) begin
                frame_err_d = 1'b1;
                gap_d       = '0;
                gh_d        = 8'h00;
                gl_d        = 8'h00;
                yh_d        = 8'h00;
                yl_d        = 8'h00;
                zh_d        = 8'h00;
                state_d     = IDLE;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            gap_q          <= '0;
            gh_q           <= 8'h00;
            gl_q           <= 8'h00;
            yh_q           <= 8'h00;
            yl_q           <= 8'h00;
            zh_q           <= 8'h00;
            gyro_q         <= 16'h0000;
            y_q            <= 16'h0000;
            z_q            <= 16'h0000;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            gh_q           <= gh_d;
            gl_q           <= gl_d;
            yh_q           <= yh_d;
            yl_q           <= yl_d;
            zh_q           <= zh_d;
            gyro_q         <= gyro_d;
            y_q            <= y_d;
            z_q            <= z_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
            busy_q         <= busy_d;
        end
    end

    assign gyroData     = gyro_q;
    assign y_accel_data = y_q;
    assign z_accel_data = z_q;
    assign sample_valid = sample_valid_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_imu_sample_framer.sv
// Randomized bench for imu_sample_framer against a queue-based frame model.
module tb_imu_sample_framer;

    localparam int TIMEOUT = 1000;
    localparam int OFFSET  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        sof = 1'b0;
    logic [15:0] gyroData, y_accel_data, z_accel_data;
    logic        sample_valid, frame_err, busy;

    imu_sample_framer #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .GYRO_OFFSET   (16'sd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .sof         (sof),
        .gyroData    (gyroData),
        .y_accel_data(y_accel_data),
        .z_accel_data(z_accel_data),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    int sv_seen  = 0;
    int timeouts_done = 0;

    logic [7:0]  partial[$];
    int          m_gap = 0;
    logic [15:0] m_g = 0, m_y = 0, m_z = 0;
    logic        m_sv = 0, m_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] gyro_exp(input logic [15:0] raw);
`ifdef IMU_FRAMER_CAL_EN
        int d;
        d = int'($signed(raw)) - OFFSET;
        if (d > 32767) return 16'h7FFF;
        if (d < -32768) return 16'h8000;
        return 16'(d);
`else
        return raw;
`endif
    endfunction

    task automatic model_reset();
        partial.delete();
        m_gap = 0; m_g = 0; m_y = 0; m_z = 0; m_sv = 0; m_err = 0;
    endtask

    // Frame-level model: the queue holds the bytes of the frame in progress.
    task automatic model_step(input logic r, input logic bv, input logic s, input logic [7:0] b);
        if (r) begin
            model_reset();
        end else begin
            m_sv = 0; m_err = 0;
            if (bv && s) begin
                if (partial.size() != 0) m_err = 1;
                partial.delete();
                partial.push_back(b);
                m_gap = 0;
            end else if (bv && partial.size() != 0) begin
                partial.push_back(b);
                m_gap = 0;
                if (partial.size() == 6) begin
                    m_g = gyro_exp({partial[0], partial[1]});
                    m_y = {partial[2], partial[3]};
                    m_z = {partial[4], partial[5]};
                    m_sv = 1;
                    partial.delete();
                end
            end else if (!bv && partial.size() != 0) begin
                m_gap++;
                if (m_gap == TIMEOUT) begin
                    m_err = 1;
                    m_gap = 0;
                    partial.delete();
                end
            end
        end
    endtask

    task automatic compare_all();
        check("sample_valid", 16'(sample_valid), 16'(m_sv));
        check("frame_err", 16'(frame_err), 16'(m_err));
        check("busy", 16'(busy), 16'(partial.size() != 0));
        check("gyroData", gyroData, m_g);
        check("y_accel", y_accel_data, m_y);
        check("z_accel", z_accel_data, m_z);
    endtask

    task automatic cycle(input logic r, input logic bv, input logic s, input logic [7:0] b);
        rst = r; byte_valid = bv; sof = s; byte_in = b;
        @(posedge clk);
        model_step(r, bv, s, b);
        #1;
        compare_all();
        if (frame_err) err_seen++;
        if (sample_valid) sv_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic send(input logic [7:0] f[6], input int first, input int count, input int max_gap);
        for (int i = first; i < first + count; i++) begin
            cycle(1'b0, 1'b1, (i == 0), f[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    logic [7:0] fa[6], fb[6];
    int e0, s0;

    initial begin
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("reset_gyro", gyroData, 16'h0000);
        check("reset_busy", 16'(busy), 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Basic frame
        fa = '{8'h00, 8'h01, 8'h28, 8'h00, 8'h20, 8'h00};
        s0 = sv_seen; e0 = err_seen;
        send(fa, 0, 6, 0);
        idle(2);
        check("basic_gyro", gyroData, gyro_exp(16'h0001));
        check("basic_y", y_accel_data, 16'h2800);
        check("basic_z", z_accel_data, 16'h2000);
        check("basic_sv_count", 16'(sv_seen - s0), 16'd1);
        check("basic_busy", 16'(busy), 16'd0);

        // Stray non-sof bytes in IDLE
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
        check("stray_err", 16'(err_seen - e0), 16'd0);
        check("stray_busy", 16'(busy), 16'd0);
        check("stray_y", y_accel_data, 16'h2800);

        // Timeout after three bytes
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        e0 = err_seen;
        send(fb, 0, 3, 0);
        idle(TIMEOUT + 5);
        check("timeout_err_count", 16'(err_seen - e0), 16'd1);
        check("timeout_busy", 16'(busy), 16'd0);
        check("timeout_y_hold", y_accel_data, 16'h2800);

        // Byte arriving on the would-be timeout cycle wins
        e0 = err_seen;
        send(fb, 0, 3, 0);
        idle(TIMEOUT - 1);
        send(fb, 3, 3, 0);
        check("race_err_count", 16'(err_seen - e0), 16'd0);
        check("race_y", y_accel_data, 16'h3344);

        // Restart by sof mid-frame
        fa = '{8'h00, 8'h10, 8'h28, 8'h00, 8'h20, 8'h00};
        e0 = err_seen; s0 = sv_seen;
        send(fb, 0, 2, 0);
        send(fa, 0, 6, 0);
        idle(1);
        check("restart_err_count", 16'(err_seen - e0), 16'd1);
        check("restart_gyro", gyroData, gyro_exp(16'h0010));
        check("restart_sv_count", 16'(sv_seen - s0), 16'd1);

        // Synchronous-edge reset mid-frame, then a full frame
        fa = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h56, 8'h78};
        e0 = err_seen;
        send(fb, 0, 4, 0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        send(fa, 0, 6, 1);
        idle(1);
        check("rst_mid_err", 16'(err_seen - e0), 16'd0);
        check("rst_mid_gyro", gyroData, gyro_exp(16'hABCD));
        check("rst_mid_z", z_accel_data, 16'h5678);

        // Asynchronous reset clears outputs before the next edge
        send(fb, 0, 3, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_busy", 16'(busy), 16'd0);
        check("async_rst_gyro", gyroData, 16'h0000);
        check("async_rst_y", y_accel_data, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Calibration boundary words
        fa = '{8'h80, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send(fa, 0, 6, 0);
        idle(1);
`ifdef IMU_FRAMER_CAL_EN
        check("cal_sat_low", gyroData, 16'h8000);
`else
        check("raw_8000", gyroData, 16'h8000);
`endif
        fa = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        send(fa, 0, 6, 0);
        idle(1);
`ifdef IMU_FRAMER_CAL_EN
        check("cal_zero", gyroData, 16'h0000);
`else
        check("raw_0004", gyroData, 16'h0004);
`endif

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            for (int i = 0; i < 6; i++) fa[i] = 8'($urandom);
            case ($urandom_range(0, 5))
                0: begin fa[0] = 8'h80; fa[1] = 8'($urandom_range(0, 3)); end
                1: begin fa[0] = 8'h7F; fa[1] = 8'hFF; end
                default: ;
            endcase
            if (kind <= 5) begin
                send(fa, 0, 6, 2);
            end else if (kind == 6) begin
                send(fa, 0, $urandom_range(1, 5), 1);
            end else if (kind == 7) begin
                for (int i = 0; i < $urandom_range(1, 3); i++)
                    cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
            end else if (kind == 8) begin
                send(fa, 0, $urandom_range(1, 5), 0);
                if (timeouts_done < 4) begin
                    timeouts_done++;
                    idle(TIMEOUT - 2 + $urandom_range(0, 4));
                end else begin
                    idle($urandom_range(0, 5));
                end
            end else begin
                if ($urandom_range(0, 3) == 0) cycle(1'b1, 1'b0, 1'b0, 8'h00);
                else idle($urandom_range(1, 3));
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imu_sample_framer.md
IMU_SAMPLE_FRAMER -- requirements
Module: imu_sample_framer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the maximum idle cycles allowed between bytes inside a frame.
REQ-002 The block SHALL have parameter GYRO_OFFSET, default 16'sd0, meaning the signed gyro bias removed when calibration is compiled in.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port byte_in, input, 8, the sensor register byte.
REQ-006 The block SHALL have port byte_valid, input, 1, which qualifies byte_in for one cycle.
REQ-007 The block SHALL have port sof, input, 1, which marks the first byte of a frame and is valid only with byte_valid.
REQ-008 The block SHALL have ports gyroData, y_accel_data and z_accel_data, each output, 16, holding the last complete sample for the complementary filter.
REQ-009 The block SHALL have port sample_valid, output, 1, a one-cycle pulse when a new sample is presented.
REQ-010 The block SHALL have port frame_err, output, 1, a one-cycle pulse when a frame is aborted.
REQ-011 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 Frame byte order SHALL be GH, GL, YH, YL, ZH, ZL; each word is assembled as {high byte, low byte}, two's complement.
REQ-013 The FSM SHALL have states IDLE, G_L, Y_H, Y_L, Z_H, Z_L; each accepted byte advances exactly one state.
REQ-014 In IDLE, byte_valid with sof=1 SHALL store GH and go to G_L; byte_valid with sof=0 SHALL be dropped without error.
REQ-015 byte_valid with sof=1 in any non-IDLE state SHALL pulse frame_err, discard partial bytes and restart with this byte as GH (state G_L).
REQ-016 Partial bytes SHALL be held in shadow registers; outputs SHALL hold the previous sample until a frame completes.
REQ-017 On the edge accepting ZL, all three outputs SHALL update together; sample_valid SHALL be high for exactly the following cycle; state SHALL return to IDLE.
REQ-018 A ZL byte with sof=1 SHALL be treated per REQ-015, not as a completion.
REQ-019 A gap counter SHALL clear on each accepted byte and count in non-IDLE states; on reaching TIMEOUT_CYCLES it SHALL pulse frame_err, discard partials and return to IDLE.
REQ-020 When timeout and byte_valid occur in the same cycle, the byte SHALL win and timeout SHALL not fire.
REQ-021 Bytes are accepted every cycle if presented; there SHALL be no back-pressure.

Reset
REQ-022 Asserting rst SHALL immediately force state IDLE and all outputs, shadow registers and the gap counter to 0.
REQ-023 Reset mid-frame SHALL discard the partial frame without a frame_err pulse; the first byte after release is handled as in IDLE.

Configuration
REQ-024 With macro IMU_FRAMER_CAL_EN defined, gyroData SHALL equal the assembled gyro word minus GYRO_OFFSET, computed in 17 bits and saturated to 16'h7FFF / 16'h8000.
REQ-025 Without IMU_FRAMER_CAL_EN, gyroData SHALL equal the raw assembled word and GYRO_OFFSET SHALL be ignored.
REQ-026 The accel outputs, timing and latency SHALL be identical with or without the macro.

Verification
REQ-027 Frame 00,01,28,00,20,00 (sof on first) -> gyroData=0001, y=2800, z=2000, one sample_valid pulse, busy low after.
REQ-028 Three bytes of a frame, then 1000 idle cycles -> frame_err pulses once, outputs unchanged, busy low.
REQ-029 Two bytes, then a new sof frame 00,10,28,00,20,00 -> one frame_err, then gyroData=0010 with sample_valid.
REQ-030 rst asserted after the fourth byte, then a full frame -> no frame_err, outputs equal the new frame.
REQ-031 CAL_EN, GYRO_OFFSET=16'sd4, gyro word 8000 -> gyroData=8000 (saturated); gyro word 0004 -> 0000.
REQ-032 Bytes with sof=0 in IDLE -> no output change, no frame_err, busy stays low.
